// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding (common with the receiver),
// data width and the default clocks-per-bit.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t IDLE    = 3'b000;
  localparam uart_state_t START   = 3'b001;
  localparam uart_state_t DATA    = 3'b010;
  localparam uart_state_t STOP    = 3'b011;
  localparam uart_state_t CLEANUP = 3'b100;

  localparam int UART_DATA_W = 8;
  localparam int CPB_DEFAULT = 217;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO for the transmit byte queue.
// Ports:
//   clk, rst_n   clock, async active-low reset (empties the queue)
//   push, din    write request / data (ignored when full)
//   pop          read request (ignored when empty)
//   dout         head of queue, valid whenever !empty
//   empty, full  decoded from the registered occupancy count
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_DATA_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, with a small byte queue in front.
// Ports:
//   clk          system clock
//   rst_n        async active-low reset; aborts any frame, empties queue
//   tx_dv        upstream byte valid
//   tx_data_in   byte to send
//   tx_ready     queue can take a byte this cycle
//   tx_data_out  serial line, idles high, registered
//   tx_active    high while start..stop is on the line
//   tx_done      one-cycle pulse after each stop bit
//
// state   | meaning
// IDLE    | line high, waiting for a queued byte
// START   | start bit (low) for CPB cycles
// DATA    | data bits 0..7, CPB cycles each
// STOP    | stop bit (high) for CPB cycles
// CLEANUP | one cycle, tx_done asserted
module uart_tx
  import uart_pkg::*;
#(
  parameter int CPB        = CPB_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tx_dv,
  input  logic [UART_DATA_W-1:0] tx_data_in,
  output logic                   tx_ready,
  output logic                   tx_data_out,
  output logic                   tx_active,
  output logic                   tx_done
);

  localparam int               CNT_W    = $clog2(CPB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

  uart_state_t            state_q, state_d;
  logic [CNT_W-1:0]       clk_cnt_q, clk_cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_W-1:0] sh_q, sh_d;
  logic                   ready_en_q;
  logic                   pending_q;
  logic                   fifo_pop;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [UART_DATA_W-1:0] fifo_dout;
  logic                   bit_end;
  logic                   line_d;

  // ready_en_q keeps tx_ready low until the first edge after reset release.
  assign tx_ready = ready_en_q & ~fifo_full;

  uart_tx_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_dv & tx_ready),
    .din   (tx_data_in),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bit_end = (clk_cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    sh_d      = sh_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        // pending_q is the queue's not-empty flag delayed one cycle, which
        // fixes accept-to-start-bit latency at two edges.
        if (pending_q && !fifo_empty) begin
          fifo_pop  = 1'b1;
          sh_d      = fifo_dout;
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = CLEANUP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      CLEANUP: state_d = IDLE;
      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  // Outputs decode the next state so they move on the transition edge.
  always_comb begin
    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = sh_d[bit_idx_d];
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      sh_q        <= '0;
      ready_en_q  <= 1'b0;
      pending_q   <= 1'b0;
      tx_data_out <= 1'b1;
      tx_active   <= 1'b0;
      tx_done     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      sh_q        <= sh_d;
      ready_en_q  <= 1'b1;
      pending_q   <= ~fifo_empty;
      tx_data_out <= line_d;
      tx_active   <= (state_d == START) || (state_d == DATA) || (state_d == STOP);
      tx_done     <= (state_d == CLEANUP);
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with CPB=4, FIFO_DEPTH=4. A line monitor decodes every
// frame cycle by cycle and compares it against a queue of expected bytes.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       tx_dv;
  logic [7:0] tx_data_in;
  logic       tx_ready;
  logic       tx_data_out;
  logic       tx_active;
  logic       tx_done;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int frames   = 0;

  logic [7:0] exp_q[$];
  int         gap_q[$];

  uart_tx #(
    .CPB        (CPB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_dv       (tx_dv),
    .tx_data_in  (tx_data_in),
    .tx_ready    (tx_ready),
    .tx_data_out (tx_data_out),
    .tx_active   (tx_active),
    .tx_done     (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx_done) done_cnt++;
    end
  end

  // Frame monitor: samples every negedge; a low line outside a frame is a start bit.
  initial begin
    int         idle_run;
    int         bad;
    int         act;
    int         bitpos;
    bit         aborted;
    logic [7:0] rx_byte;
    logic [7:0] e;
    idle_run = 0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_data_out === 1'b0) begin
        gap_q.push_back(idle_run);
        bad = 0; act = 0; aborted = 0; rx_byte = '0;
        for (int s = 0; s < 10*CPB; s++) begin
          if (s > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1;
            break;
          end
          bitpos = s / CPB;
          if (tx_active === 1'b1) act++;
          if (bitpos == 0) begin
            if (tx_data_out !== 1'b0) bad++;
          end else if (bitpos == 9) begin
            if (tx_data_out !== 1'b1) bad++;
          end else if (s % CPB == 0) begin
            rx_byte[bitpos-1] = tx_data_out;
          end else if (tx_data_out !== rx_byte[bitpos-1]) begin
            bad++;
          end
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            check("frame_unexpected", {24'd0, rx_byte}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("frame_byte", {24'd0, rx_byte}, {24'd0, e});
          end
          check("frame_glitch", bad, 0);
          check("frame_active_cycles", act, 10*CPB);
          @(negedge clk);
          check("done_pulse", {31'd0, tx_done}, 1);
          check("active_after_stop", {31'd0, tx_active}, 0);
          frames++;
          idle_run = 1;
        end else begin
          idle_run = 0;
        end
      end else if (rst_n) begin
        idle_run++;
      end else begin
        idle_run = 0;
      end
    end
  end

  // Drive one byte for the next edge; expected ready comes from the bench's own occupancy view.
  task automatic drive_byte(input logic [7:0] d, input logic exp_rdy, input string tag);
    tx_dv      = 1'b1;
    tx_data_in = d;
    check(tag, {31'd0, tx_ready}, {31'd0, exp_rdy});
    if (exp_rdy) exp_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, done_cnt, target);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_line_low(input int budget, input string tag);
    int n = 0;
    while (tx_data_out !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, tx_data_out}, 0);
  endtask

  initial begin
    int low_cnt;
    int done_snap;
    int frames_snap;
    logic [7:0] burst [6];
    rst_n      = 1'b0;
    tx_dv      = 1'b0;
    tx_data_in = '0;

    // Reset
    repeat (5) @(negedge clk);
    check("rst_line", {31'd0, tx_data_out}, 1);
    check("rst_active", {31'd0, tx_active}, 0);
    check("rst_done", {31'd0, tx_done}, 0);
    check("rst_ready", {31'd0, tx_ready}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, tx_ready}, 1);
    check("line_after_rst", {31'd0, tx_data_out}, 1);
    repeat (3) @(negedge clk);

    // Single byte with latency check
    drive_byte(8'hA5, 1'b1, "ready_single");
    tx_dv = 1'b0;
    check("lat_k0_high", {31'd0, tx_data_out}, 1);
    @(negedge clk);
    check("lat_k1_high", {31'd0, tx_data_out}, 1);
    @(negedge clk);
    check("lat_k2_low", {31'd0, tx_data_out}, 0);
    check("lat_k2_active", {31'd0, tx_active}, 1);
    wait_done(1, 100, "single_done");
    check("single_frames", frames, 1);

    // Back-to-back
    gap_q.delete();
    drive_byte(8'h00, 1'b1, "ready_b2b0");
    drive_byte(8'hFF, 1'b1, "ready_b2b1");
    drive_byte(8'h3C, 1'b1, "ready_b2b2");
    tx_dv = 1'b0;
    wait_done(4, 400, "b2b_done");
    check("b2b_frames", frames, 4);
    check("b2b_gap_count", gap_q.size(), 3);
    if (gap_q.size() == 3) begin
      check("b2b_gap1", gap_q[1], 2);
      check("b2b_gap2", gap_q[2], 2);
    end

    // Full queue: first frame in flight, then six offered, four fit
    drive_byte(8'h11, 1'b1, "ready_full0");
    tx_dv = 1'b0;
    wait_line_low(10, "full_start");
    for (int i = 0; i < 6; i++) begin
      burst[i] = 8'h21 + 8'(i);
      drive_byte(burst[i], (i < DEPTH) ? 1'b1 : 1'b0, "ready_full");
    end
    tx_dv = 1'b0;
    check("ready_while_full", {31'd0, tx_ready}, 0);
    wait_done(9, 600, "full_done");
    check("full_frames", frames, 9);
    check("queue_drained", exp_q.size(), 0);

    // Reset mid-frame during data bit 3
    drive_byte(8'h00, 1'b1, "ready_abort0");
    drive_byte(8'h5A, 1'b1, "ready_abort1");
    tx_dv = 1'b0;
    wait_line_low(10, "abort_start");
    repeat (4*CPB + 1) @(negedge clk);
    check("abort_pre_low", {31'd0, tx_data_out}, 0);
    check("abort_pre_active", {31'd0, tx_active}, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_line_high", {31'd0, tx_data_out}, 1);
    check("abort_active_low", {31'd0, tx_active}, 0);
    check("abort_ready_low", {31'd0, tx_ready}, 0);
    exp_q.delete();
    done_snap   = done_cnt;
    frames_snap = frames;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 30*CPB; i++) begin
      @(negedge clk);
      if (tx_data_out !== 1'b1) low_cnt++;
    end
    check("abort_no_line_activity", low_cnt, 0);
    check("abort_no_done", done_cnt, done_snap);
    check("abort_no_frames", frames, frames_snap);
    check("abort_ready_back", {31'd0, tx_ready}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter, 8N1 framing, LSB first. It pairs with the team's UART receiver and uses the same clocks-per-bit convention. A small byte FIFO sits on the parallel side, so upstream logic can queue several bytes without waiting for each frame to finish. Placed at the TX pin boundary of the UART subsystem.

Parameters:
CPB, 217, clock cycles per serial bit (>= 2); bit timing is exactly CPB cycles per bit.
FIFO_DEPTH, 4, byte queue depth; power of two, >= 2.

Ports:
clk  input  1  system clock; all state on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
tx_dv  input  1  upstream byte valid.
tx_data_in  input  8  byte to transmit.
tx_ready  output  1  FIFO can accept a byte this cycle.
tx_data_out  output  1  serial line; idles high; registered.
tx_active  output  1  high while a frame (start..stop) is on the line.
tx_done  output  1  one-cycle pulse after each stop bit completes.

Behaviour:
- Reset (async, rst_n=0): tx_data_out=1, tx_ready=0 while in reset, tx_active=0, tx_done=0. FIFO is emptied; FSM goes to IDLE; counters are cleared. tx_ready=1 from the first cycle after rst_n deasserts.
- Reset mid-frame aborts the frame immediately: the line returns high asynchronously and queued bytes are discarded.
- Handshake: a byte is accepted on an edge where tx_dv & tx_ready. tx_ready = !full, derived from registered occupancy only. When full, a push is refused even if a pop occurs in the same cycle. tx_dv while !tx_ready is ignored (no overflow, no corruption).
- Simultaneous push and pop (not full): both take effect; occupancy is unchanged.
- FIFO: registered occupancy count 0..FIFO_DEPTH; read/write pointers wrap modulo FIFO_DEPTH; data leaves in arrival order.
- FSM states:
  - IDLE: tx_data_out=1. If the FIFO is non-empty, pop its head into shift register sh, clear clk_cnt and bit_idx, and go to START.
  - START: tx_data_out=0 for CPB cycles, then go to DATA.
  - DATA: tx_data_out=sh[bit_idx] for CPB cycles per bit. bit_idx runs 0..7, then go to STOP.
  - STOP: tx_data_out=1 for CPB cycles, then go to CLEANUP.
  - CLEANUP: tx_data_out=1, tx_done=1 for exactly this one cycle, then go to IDLE.
  - Illegal state encoding goes to IDLE.
- clk_cnt width is $clog2(CPB). The bit period ends when clk_cnt == CPB-1; clk_cnt then returns to 0.
- tx_data_out and tx_active are registered from the next-state decode, so the line changes on the same edge as the state transition and never glitches.
- tx_active=1 exactly in START, DATA and STOP.
- Latency: a byte accepted at edge k with the FIFO empty and the FSM in IDLE drives the line low from edge k+2.
- Frame timing: start bit to end of stop bit is exactly 10*CPB cycles.
- Back-to-back queued bytes: the line stays high for 2 cycles (CLEANUP + IDLE) between one stop bit and the next start bit.
- Accepting bytes during transmission does not perturb the frame in flight.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants: IDLE=3'b000, START=3'b001, DATA=3'b010, STOP=3'b011, CLEANUP=3'b100 (same numbering as the receiver);
  - UART_DATA_W=8;
  - default CPB=217.
- One sub-module: uart_tx_fifo, a synchronous FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: clk, rst_n, push, din, pop, dout, empty, full.
  - Show-ahead: dout is valid whenever !empty.
- The FSM, counters and shift register stay in uart_tx.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles, release → tx_data_out=1, tx_active=0, tx_done=0; tx_ready=1 one cycle after release.
- Single byte, CPB=4, push 0xA5 at edge k → line low from edge k+2 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, stop high for 4 cycles, tx_done pulses once; total 40 active cycles.
- Back-to-back, CPB=4: push 0x00, 0xFF, 0x3C in consecutive cycles → three correct frames in order, each separated by exactly 2 idle-high cycles; 3 tx_done pulses.
- Full FIFO, FIFO_DEPTH=4: push 6 bytes continuously while the first frame is in flight → tx_ready drops after occupancy reaches 4; bytes offered while !tx_ready are dropped; exactly the accepted bytes are transmitted, in order.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 → line high in the same cycle (async); after release the FIFO is empty and no further frames or tx_done occur.
- Loopback: wire tx_data_out to the team's receiver with matching CPB=217, send 0x55 and 0xC3 → receiver rx_dv pulses twice, with rx_data_out=0x55 then 0xC3.
